spi_seg_scan_ctrl: RTL

SPI_SEG_SCAN_CTRL -- requirements
Module: spi_seg_scan_ctrl

---
 rtl/seg_ctrl_pkg.sv | 20 ++
 rtl/spi_frame_rx.sv | 79 +++++++
 rtl/spi_seg_scan_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/seg_ctrl_pkg.sv
// Shared constants, opcodes and scan-state type for the SPI-driven 4-digit
// 7-segment scan controller.
package seg_ctrl_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [3:0] OP_WRITE_DIGIT = 4'h1;
    localparam logic [3:0] OP_WRITE_CTRL  = 4'h2;
    localparam logic [3:0] OP_CLEAR       = 4'h3;

    typedef enum logic {
        ST_DRIVE = 1'b0,
        ST_BLANK = 1'b1
    } scan_state_e;

    function automatic logic op_known(input logic [3:0] op);
        return (op == OP_WRITE_DIGIT) || (op == OP_WRITE_CTRL) || (op == OP_CLEAR);
    endfunction

endpackage

// File: rtl/spi_frame_rx.sv
// SPI mode-0 receiver: synchronizes the asynchronous pins into clk, shifts MSB
// first and emits a 16-bit frame with a one-cycle frame_vld or frame_err.
module spi_frame_rx (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic [15:0] frame,
    output logic        frame_vld,
    output logic        frame_err
);

    logic [1:0]  sclk_sync;
    logic [1:0]  cs_sync;
    logic [1:0]  mosi_sync;
    logic        sclk_q;
    logic        cs_q;
    logic [1:0]  warm;
    logic        armed;
    logic [4:0]  bit_cnt;
    logic [15:0] shreg;

    logic sclk_rise;
    logic cs_fall;
    logic cs_rise;

    assign sclk_rise = sclk_sync[1] && !sclk_q;
    assign cs_fall   = cs_q && !cs_sync[1];
    assign cs_rise   = !cs_q && cs_sync[1];

    // armed is only set once cs_n has really been seen high after reset, so a
    // frame that was in flight across reset can never be accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            warm      <= 2'b00;
            armed     <= 1'b0;
            bit_cnt   <= 5'd0;
            shreg     <= 16'h0000;
            frame     <= 16'h0000;
            frame_vld <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], spi_sclk};
            cs_sync   <= {cs_sync[0], spi_cs_n};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            sclk_q    <= sclk_sync[1];
            cs_q      <= cs_sync[1];
            warm      <= {warm[0], 1'b1};
            frame_vld <= 1'b0;
            frame_err <= 1'b0;
            if (warm[1] && cs_sync[1]) begin
                armed <= 1'b1;
            end
            if (cs_fall) begin
                bit_cnt <= 5'd0;
            end else if (sclk_rise && !cs_sync[1] && armed) begin
                shreg <= {shreg[14:0], mosi_sync[1]};
                if (bit_cnt != 5'd17) begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end
            if (cs_rise) begin
                if (armed && bit_cnt == 5'd16) begin
                    frame     <= shreg;
                    frame_vld <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_seg_scan_ctrl.sv
// SPI-programmed 4-digit multiplexed 7-segment controller with DRIVE/BLANK scan.
// Optional blinking is compiled in with the SEG_BLINK_EN macro.
module spi_seg_scan_ctrl
    import seg_ctrl_pkg::*;
#(
    parameter logic [23:0] SCAN_DIV  = 24'd10_000,
    parameter logic [7:0]  BLINK_DIV = 8'd100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic [6:0]  seg_out,
    output logic        dp_out,
    output logic [3:0]  dig_en,
    output logic        frame_err,
    output scan_state_e scan_state
);

    logic [15:0] frame;
    logic        rx_vld;
    logic        rx_err;
    logic [7:0]  digit_buf [NUM_DIGITS];
    logic        disp_en;
    logic        blink_en;
    logic        blink_blank;

    scan_state_e state, state_nxt;
    logic [23:0] scan_cnt, scan_cnt_nxt;
    logic [1:0]  idx, idx_nxt;
    logic        wrap;

    logic unused_cmd_bits;
    assign unused_cmd_bits = ^frame[11:10];

    spi_frame_rx u_rx (
        .clk       (clk),
        .rst       (rst),
        .spi_sclk  (spi_sclk),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .frame     (frame),
        .frame_vld (rx_vld),
        .frame_err (rx_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_buf[i] <= 8'h00;
            end
            disp_en   <= 1'b1;
            blink_en  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= rx_err || (rx_vld && !op_known(frame[15:12]));
            if (rx_vld) begin
                case (frame[15:12])
                    OP_WRITE_DIGIT: digit_buf[frame[9:8]] <= frame[7:0];
                    OP_WRITE_CTRL: begin
                        disp_en  <= frame[0];
                        blink_en <= frame[1];
                    end
                    OP_CLEAR: begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            digit_buf[i] <= 8'h00;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_DRIVE;
            scan_cnt <= 24'd0;
            idx      <= 2'd0;
        end else begin
            state    <= state_nxt;
            scan_cnt <= scan_cnt_nxt;
            idx      <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        scan_cnt_nxt = scan_cnt;
        idx_nxt      = idx;
        wrap         = 1'b0;
        if (state == ST_DRIVE) begin
            if (scan_cnt == SCAN_DIV - 24'd1) begin
                state_nxt    = ST_BLANK;
                scan_cnt_nxt = 24'd0;
            end else begin
                scan_cnt_nxt = scan_cnt + 24'd1;
            end
        end else begin
            state_nxt = ST_DRIVE;
            idx_nxt   = idx + 2'd1;
            wrap      = (idx == 2'd3);
        end
    end

`ifdef SEG_BLINK_EN
    logic [7:0] blink_cnt;
    logic       blink_phase;

    // The phase flips after BLINK_DIV full rotations, counted at the 3->0 wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= 8'd0;
            blink_phase <= 1'b0;
        end else if (wrap) begin
            if (blink_cnt == BLINK_DIV - 8'd1) begin
                blink_cnt   <= 8'd0;
                blink_phase <= !blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 8'd1;
            end
        end
    end

    assign blink_blank = blink_en && blink_phase;
`else
    logic unused_blink;
    assign unused_blink = blink_en ^ wrap;
    assign blink_blank  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dig_en  <= 4'b0000;
            seg_out <= 7'h00;
            dp_out  <= 1'b0;
        end else if (state == ST_DRIVE && disp_en && !blink_blank) begin
            dig_en  <= 4'b0001 << idx;
            seg_out <= digit_buf[idx][6:0];
            dp_out  <= digit_buf[idx][7];
        end else begin
            dig_en  <= 4'b0000;
            seg_out <= 7'h00;
            dp_out  <= 1'b0;
        end
    end

    assign scan_state = state;

endmodule
